// File: rtl/fix_msg_csr_slave.sv
// CSR slave buffering FIX parser message bytes for host readout, with sticky
// status, FIFO level, level interrupt and one-cycle session commands.
module fix_msg_csr_slave #(
  parameter int              DATA_W   = 8,
  parameter int              DEPTH    = 16,
  parameter logic [DATA_W-1:0] CONN_CMD = 8'hDD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  output logic [DATA_W-1:0] slave_readdata,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  input  logic              msg_valid,
  input  logic [DATA_W-1:0] msg_data,
  input  logic              msg_last,
  output logic              msg_ready,
  output logic [DATA_W-1:0] session_initiate,
  output logic              irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_RDATA  = 3'd1;
  localparam logic [2:0] ADDR_LEVEL  = 3'd2;
  localparam logic [2:0] ADDR_IRQ_EN = 3'd3;
  localparam logic [2:0] ADDR_CONN   = 3'd6;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              done_r;
  logic              underflow_r;
  logic              irq_en_r;
  logic [DATA_W-1:0] readdata_r;
  logic [DATA_W-1:0] session_r;
  logic              irq_r;

  logic              empty_s;
  logic              full_s;
  logic              conn_wr_s;
  logic              flush_s;
  logic              status_wr_s;
  logic              rd_fifo_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] status_s;
  logic [DATA_W-1:0] rdata_nxt_s;

  assign empty_s     = (count_r == {CW{1'b0}});
  assign full_s      = (count_r == CW'(DEPTH));
  assign conn_wr_s   = slave_write && (slave_address == ADDR_CONN);
  assign flush_s     = conn_wr_s && (slave_writedata == CONN_CMD);
  assign status_wr_s = slave_write && (slave_address == ADDR_STATUS);
  assign rd_fifo_s   = slave_read && (slave_address == ADDR_RDATA);
  assign msg_ready   = !full_s && !flush_s;
  assign push_s      = msg_valid && msg_ready;
  assign pop_s       = rd_fifo_s && !empty_s && !flush_s;
  assign status_s    = {{(DATA_W-4){1'b0}}, underflow_r, full_s, empty_s, done_r};

  // Read-data mux; every view reflects state before the current edge.
  always_comb begin
    rdata_nxt_s = {DATA_W{1'b0}};
    case (slave_address)
      ADDR_STATUS: rdata_nxt_s = status_s;
      ADDR_RDATA: begin
        if (!empty_s) begin
          rdata_nxt_s = mem_r[rd_ptr_r];
        end else begin
          rdata_nxt_s = {DATA_W{1'b0}};
        end
      end
      ADDR_LEVEL:  rdata_nxt_s = DATA_W'(count_r);
      ADDR_IRQ_EN: rdata_nxt_s = DATA_W'(irq_en_r);
      default:     rdata_nxt_s = {DATA_W{1'b0}};
    endcase
  end

  // Message storage; contents survive reset, only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= msg_data;
    end
  end

  // FIFO pointers, fill count and sticky status; a flush overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      done_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush_s) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      done_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // Set events beat a same-cycle W1C clear.
      if (push_s && msg_last) begin
        done_r <= 1'b1;
      end else if (status_wr_s && slave_writedata[0]) begin
        done_r <= 1'b0;
      end
      if (rd_fifo_s && empty_s) begin
        underflow_r <= 1'b1;
      end else if (status_wr_s && slave_writedata[3]) begin
        underflow_r <= 1'b0;
      end
    end
  end

  // Host-facing registers: read data, interrupt enable, command pulse and irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r <= {DATA_W{1'b0}};
      irq_en_r   <= 1'b0;
      session_r  <= {DATA_W{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      if (slave_read) begin
        readdata_r <= rdata_nxt_s;
      end
      if (slave_write && (slave_address == ADDR_IRQ_EN)) begin
        irq_en_r <= slave_writedata[0];
      end
      session_r <= conn_wr_s ? slave_writedata : {DATA_W{1'b0}};
      irq_r     <= irq_en_r && done_r;
    end
  end

  assign slave_readdata   = readdata_r;
  assign session_initiate = session_r;
  assign irq              = irq_r;

endmodule

// File: tb/tb_fix_msg_csr_slave.sv
// Self-checking bench for fix_msg_csr_slave: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_fix_msg_csr_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] slave_address = 3'd0;
  logic       slave_read = 1'b0;
  logic [7:0] slave_readdata;
  logic       slave_write = 1'b0;
  logic [7:0] slave_writedata = 8'h00;
  logic       msg_valid = 1'b0;
  logic [7:0] msg_data = 8'h00;
  logic       msg_last = 1'b0;
  logic       msg_ready;
  logic [7:0] session_initiate;
  logic       irq;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  bit [7:0] q[$];
  bit       m_done, m_under, m_irq_en, m_irq;
  bit [7:0] m_rdata, m_sess;
  bit       obs_ready, exp_ready;

  fix_msg_csr_slave dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read),
    .slave_readdata(slave_readdata), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .msg_valid(msg_valid),
    .msg_data(msg_data), .msg_last(msg_last), .msg_ready(msg_ready),
    .session_initiate(session_initiate), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] m_status();
    return {4'h0, m_under, q.size() == 16, q.size() == 0, m_done};
  endfunction

  task automatic model_reset();
    q.delete();
    m_done = 0; m_under = 0; m_irq_en = 0; m_irq = 0; m_rdata = 0; m_sess = 0;
  endtask

  // Drive one cycle of inputs and advance the model across the clock edge.
  task automatic step(input bit rd, input bit wr, input bit [2:0] a, input bit [7:0] wd,
                      input bit v, input bit [7:0] d, input bit l);
    bit flush, nirq, was_empty;
    bit [7:0] rv;
    slave_read = rd; slave_write = wr; slave_address = a; slave_writedata = wd;
    msg_valid = v; msg_data = d; msg_last = l;
    #1;
    obs_ready = msg_ready;
    flush = wr && a == 3'd6 && wd == 8'hDD;
    exp_ready = (q.size() < 16) && !flush;
    case (a)
      3'd0: rv = m_status();
      3'd1: rv = (q.size() != 0) ? q[0] : 8'h00;
      3'd2: rv = 8'(q.size());
      3'd3: rv = {7'd0, m_irq_en};
      default: rv = 8'h00;
    endcase
    nirq = m_irq_en && m_done;
    was_empty = (q.size() == 0);
    @(posedge clk);
    if (rd) m_rdata = rv;
    m_sess = (wr && a == 3'd6) ? wd : 8'h00;
    m_irq = nirq;
    if (wr && a == 3'd3) m_irq_en = wd[0];
    if (flush) begin
      q.delete(); m_done = 0; m_under = 0;
    end else begin
      if (wr && a == 3'd0) begin
        if (wd[0]) m_done = 0;
        if (wd[3]) m_under = 0;
      end
      if (rd && a == 3'd1) begin
        if (was_empty) m_under = 1;
        else void'(q.pop_front());
      end
      if (v && exp_ready) begin
        q.push_back(d);
        if (l) m_done = 1;
      end
    end
    #1;
    slave_read = 0; slave_write = 0; msg_valid = 0; msg_last = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (slave_readdata !== 8'h00) begin n_fail++; $display("FAIL reset_readdata: got %h want 00", slave_readdata); end
    n_cmp++; if (session_initiate !== 8'h00) begin n_fail++; $display("FAIL reset_session: got %h want 00", session_initiate); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_cmp++; if (msg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", msg_ready); end
    step(1, 0, 3'd2, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h00) begin n_fail++; $display("FAIL reset_level: got %h want 00", slave_readdata); end
    step(1, 0, 3'd3, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h00) begin n_fail++; $display("FAIL reset_irq_en: got %h want 00", slave_readdata); end
  endtask

  task automatic test_basic();
    bit [7:0] bytes[3] = '{8'h38, 8'h3D, 8'h46};
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'd0, 0, 1, bytes[i], i == 2);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready%0d: got %b want 1", i, obs_ready); end
    end
    step(1, 0, 3'd2, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h03) begin n_fail++; $display("FAIL basic_level: got %h want 03", slave_readdata); end
    step(1, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h01) begin n_fail++; $display("FAIL basic_status: got %h want 01", slave_readdata); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 3'd1, 0, 0, 0, 0);
      n_cmp++; if (slave_readdata !== bytes[i]) begin n_fail++; $display("FAIL basic_rdata%0d: got %h want %h", i, slave_readdata, bytes[i]); end
    end
    step(1, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h03) begin n_fail++; $display("FAIL basic_status_end: got %h want 03", slave_readdata); end
  endtask

  task automatic test_fill();
    bit [7:0] sent[$];
    bit [7:0] d;
    step(0, 1, 3'd0, 8'h09, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      d = 8'($urandom);
      step(0, 0, 3'd0, 0, 1, d, 0);
      n_cmp++; if (obs_ready !== (i < 16)) begin n_fail++; $display("FAIL fill_ready%0d: got %b want %b", i, obs_ready, i < 16); end
      if (i < 16) sent.push_back(d);
    end
    step(1, 0, 3'd2, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h10) begin n_fail++; $display("FAIL fill_level: got %h want 10", slave_readdata); end
    step(1, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h04) begin n_fail++; $display("FAIL fill_status: got %h want 04", slave_readdata); end
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 3'd1, 0, 0, 0, 0);
      n_cmp++; if (slave_readdata !== sent[i]) begin n_fail++; $display("FAIL fill_rdata%0d: got %h want %h", i, slave_readdata, sent[i]); end
    end
  endtask

  task automatic test_underflow();
    step(1, 0, 3'd1, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h00) begin n_fail++; $display("FAIL uf_rdata: got %h want 00", slave_readdata); end
    step(1, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h0A) begin n_fail++; $display("FAIL uf_status: got %h want 0a", slave_readdata); end
    step(0, 1, 3'd0, 8'h08, 0, 0, 0);
    step(1, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h02) begin n_fail++; $display("FAIL uf_clear: got %h want 02", slave_readdata); end
  endtask

  task automatic test_irq();
    step(0, 1, 3'd3, 8'h01, 0, 0, 0);
    step(0, 0, 3'd0, 0, 1, 8'h5A, 1);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b want 0", irq); end
    step(0, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
    step(0, 1, 3'd0, 8'h01, 0, 0, 0);
    step(0, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
    step(1, 0, 3'd1, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h5A) begin n_fail++; $display("FAIL irq_rdata: got %h want 5a", slave_readdata); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(0, 0, 3'd0, 0, 1, 8'(8'h20 + i), i == 4);
    step(0, 1, 3'd6, 8'hDD, 1, 8'h77, 0);
    n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", obs_ready); end
    n_cmp++; if (session_initiate !== 8'hDD) begin n_fail++; $display("FAIL flush_pulse: got %h want dd", session_initiate); end
    step(1, 0, 3'd2, 0, 0, 0, 0);
    n_cmp++; if (session_initiate !== 8'h00) begin n_fail++; $display("FAIL flush_pulse_end: got %h want 00", session_initiate); end
    n_cmp++; if (slave_readdata !== 8'h00) begin n_fail++; $display("FAIL flush_level: got %h want 00", slave_readdata); end
    step(1, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h02) begin n_fail++; $display("FAIL flush_status: got %h want 02", slave_readdata); end
    step(0, 0, 3'd0, 0, 1, 8'hA1, 0);
    step(0, 0, 3'd0, 0, 1, 8'hA2, 0);
    step(0, 1, 3'd6, 8'h11, 0, 0, 0);
    n_cmp++; if (session_initiate !== 8'h11) begin n_fail++; $display("FAIL conn_pulse: got %h want 11", session_initiate); end
    step(1, 0, 3'd2, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h02) begin n_fail++; $display("FAIL conn_level: got %h want 02", slave_readdata); end
    step(1, 0, 3'd1, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'hA1) begin n_fail++; $display("FAIL conn_rdata: got %h want a1", slave_readdata); end
    step(1, 0, 3'd1, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) step(0, 0, 3'd0, 0, 1, 8'($urandom), 0);
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 3'd1, 0, 1, 8'($urandom), 0);
      n_cmp++; if (slave_readdata !== m_rdata) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", i, slave_readdata, m_rdata); end
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want %b", i, obs_ready, exp_ready); end
    end
    step(1, 0, 3'd2, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'(q.size())) begin n_fail++; $display("FAIL b2b_level: got %h want %h", slave_readdata, q.size()); end
  endtask

  task automatic test_random();
    bit rd, wr, v, l;
    bit [2:0] a;
    bit [7:0] wd;
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom % 2) == 0;
      wr = ($urandom % 4) == 0;
      a  = ($urandom % 3 == 0) ? 3'd1 : 3'($urandom);
      wd = 8'($urandom);
      if (a == 3'd6 && ($urandom % 4) == 0) wd = 8'hDD;
      v  = ($urandom % 4) != 0;
      l  = ($urandom % 8) == 0;
      step(rd, wr, a, wd, v, 8'($urandom), l);
      n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready%0d: got %b want %b", i, obs_ready, exp_ready); end
      n_cmp++; if (slave_readdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata%0d: got %h want %h", i, slave_readdata, m_rdata); end
      n_cmp++; if (session_initiate !== m_sess) begin n_fail++; $display("FAIL rnd_session%0d: got %h want %h", i, session_initiate, m_sess); end
      n_cmp++; if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq%0d: got %b want %b", i, irq, m_irq); end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 3'd3, 8'h01, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 3'd0, 0, 1, 8'($urandom), i == 3);
    step(1, 0, 3'd2, 0, 0, 0, 0);
    step(0, 1, 3'd6, 8'h11, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (slave_readdata !== 8'h00) begin n_fail++; $display("FAIL mid_readdata: got %h want 00", slave_readdata); end
    n_cmp++; if (session_initiate !== 8'h00) begin n_fail++; $display("FAIL mid_session: got %h want 00", session_initiate); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq: got %b want 0", irq); end
    n_cmp++; if (msg_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", msg_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step(1, 0, 3'd2, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h00) begin n_fail++; $display("FAIL mid_level: got %h want 00", slave_readdata); end
    step(1, 0, 3'd0, 0, 0, 0, 0);
    n_cmp++; if (slave_readdata !== 8'h02) begin n_fail++; $display("FAIL mid_status: got %h want 02", slave_readdata); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_underflow();
    test_irq();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
